axis_mmio_rd_scheduler: RTL

AXIS_MMIO_RD_SCHEDULER -- requirements
Module: axis_mmio_rd_scheduler

---
 rtl/axis_mmio_rd_scheduler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/axis_mmio_rd_scheduler.sv
// Credit-based round-robin MMIO read scheduler feeding an AVMM master port.
// Define MMIO_SCHED_PRIO0_EN to give requester 0 strict priority.
module axis_mmio_rd_scheduler #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 256,
    parameter int AVMM_ADDR_WIDTH = 20
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [NUM_REQ*AVMM_ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQ*64-1:0]                  req_info,
    output logic                                   avmm_read,
    output logic [AVMM_ADDR_WIDTH-1:0]             avmm_address,
    input  logic                                   avmm_waitrequest,
    output logic                                   tlp_rd_strb,
    output logic [9:0]                             tlp_rd_tag,
    output logic [13:0]                            tlp_rd_length,
    output logic [15:0]                            tlp_rd_req_id,
    output logic [23:0]                            tlp_rd_low_addr,
    input  logic                                   cpl_done,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   credits_avail,
    output logic                                   sched_error
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int IW = $clog2(NUM_REQ);
    localparam int AW = AVMM_ADDR_WIDTH;
    localparam logic [CW-1:0] CRED_MAX = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] CRED_ONE = CW'(1);
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] last_q;
    logic [AW-1:0] addr_q;
    logic [63:0]   info_q;
    logic [CW-1:0] credits_q;
    logic          err_q;

    logic [IW-1:0] gnt_idx;
    logic          gnt_found;
    logic          grant_en;
    logic          issue_done;
    int            idx;

    // Rotating search starting just after the last winner.
    always_comb begin
        gnt_idx   = '0;
        gnt_found = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(last_q) + 1 + k) % NUM_REQ;
`ifdef MMIO_SCHED_PRIO0_EN
            if (!gnt_found && idx != 0 && req_valid[idx]) begin
`else
            if (!gnt_found && req_valid[idx]) begin
`endif
                gnt_found = 1'b1;
                gnt_idx   = IW'(idx);
            end
        end
`ifdef MMIO_SCHED_PRIO0_EN
        if (req_valid[0]) begin
            gnt_found = 1'b1;
            gnt_idx   = '0;
        end
`endif
    end

    assign grant_en   = !rst && state_q == IDLE && credits_q != '0 && gnt_found;
    assign issue_done = !rst && state_q == ISSUE && !avmm_waitrequest;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_en) state_d = ISSUE;
            ISSUE:   if (!avmm_waitrequest) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are gated by rst so an abandoned command never strobes.
    always_comb begin
        req_ready       = '0;
        avmm_read       = 1'b0;
        avmm_address    = '0;
        tlp_rd_strb     = 1'b0;
        tlp_rd_tag      = '0;
        tlp_rd_length   = '0;
        tlp_rd_req_id   = '0;
        tlp_rd_low_addr = '0;
        if (grant_en) req_ready[gnt_idx] = 1'b1;
        if (!rst && state_q == ISSUE) begin
            avmm_read    = 1'b1;
            avmm_address = addr_q;
        end
        if (issue_done) begin
            tlp_rd_strb     = 1'b1;
            tlp_rd_tag      = info_q[63:54];
            tlp_rd_length   = info_q[53:40];
            tlp_rd_req_id   = info_q[39:24];
            tlp_rd_low_addr = info_q[23:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q    <= LAST_RST;
            addr_q    <= '0;
            info_q    <= '0;
            credits_q <= CRED_MAX;
            err_q     <= 1'b0;
        end else begin
            if (grant_en) begin
                addr_q <= req_addr[gnt_idx*AW +: AW];
                info_q <= req_info[gnt_idx*64 +: 64];
`ifdef MMIO_SCHED_PRIO0_EN
                if (gnt_idx != '0) last_q <= gnt_idx;
`else
                last_q <= gnt_idx;
`endif
            end
            if (cpl_done && !issue_done) begin
                if (credits_q == CRED_MAX) err_q <= 1'b1;
                else                       credits_q <= credits_q + CRED_ONE;
            end else if (issue_done && !cpl_done) begin
                credits_q <= credits_q - CRED_ONE;
            end
        end
    end

    assign credits_avail = credits_q;
    assign sched_error   = err_q;

endmodule
